// File: rtl/uart_stim_tx.sv
// 8N1 UART transmitter: bytes enter a small FIFO over valid/ready and are
// serialised LSB-first at CLK_DIV clocks per bit. Line idles high.
module uart_stim_tx #(
  parameter int CLK_DIV    = 278,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push_s;
  logic            pop_s;
  logic            bound_s;
  logic            fifo_ne_s;

  assign push_s    = tx_valid & ready_q;
  assign bound_s   = (div_q == DIV_LAST);
  assign fifo_ne_s = (cnt_q != '0);

  // Frame sequencer; the line level and tx_done are derived from the next state
  // so that both come straight out of flops.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_ne_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          div_d   = '0;
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bound_s) begin
          state_d = DATA;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DATA: begin
        if (bound_s) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      STOP: begin
        if (bound_s) begin
          div_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = 3'd0;
            // Chain straight into the next frame when a byte is waiting.
            if (fifo_ne_s) begin
              pop_s   = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = 3'd0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (div_d == DIV_LAST) && (bit_d == STOP_LAST);
  end

  // FIFO pointer/occupancy update; a full FIFO never accepts, even when popping.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != FULL_CNT);
    busy_d  = (state_d != IDLE) || (cnt_d != '0);
  end

  // Control and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign tx_ready  = ready_q;
  assign serial_tx = tx_q;
  assign busy      = busy_q;
  assign tx_done   = done_q;

endmodule
